// File: rtl/blake_pkg.sv
// Shared BLAKE-256 constants and the round controller state encoding.
// Imported by the controller, its sigma ROM and the compression core.
package blake_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VINIT,
        ST_RND,
        ST_FINAL,
        ST_DONE
    } state_t;

    // Message word permutation, one row per round (row index wraps every 10 rounds).
    localparam logic [3:0] SIGMA [10][16] = '{
        '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF},
        '{4'hE, 4'hA, 4'h4, 4'h8, 4'h9, 4'hF, 4'hD, 4'h6, 4'h1, 4'hC, 4'h0, 4'h2, 4'hB, 4'h7, 4'h5, 4'h3},
        '{4'hB, 4'h8, 4'hC, 4'h0, 4'h5, 4'h2, 4'hF, 4'hD, 4'hA, 4'hE, 4'h3, 4'h6, 4'h7, 4'h1, 4'h9, 4'h4},
        '{4'h7, 4'h9, 4'h3, 4'h1, 4'hD, 4'hC, 4'hB, 4'hE, 4'h2, 4'h6, 4'h5, 4'hA, 4'h4, 4'h0, 4'hF, 4'h8},
        '{4'h9, 4'h0, 4'h5, 4'h7, 4'h2, 4'h4, 4'hA, 4'hF, 4'hE, 4'h1, 4'hB, 4'hC, 4'h6, 4'h8, 4'h3, 4'hD},
        '{4'h2, 4'hC, 4'h6, 4'hA, 4'h0, 4'hB, 4'h8, 4'h3, 4'h4, 4'hD, 4'h7, 4'h5, 4'hF, 4'hE, 4'h1, 4'h9},
        '{4'hC, 4'h5, 4'h1, 4'hF, 4'hE, 4'hD, 4'h4, 4'hA, 4'h0, 4'h7, 4'h6, 4'h3, 4'h9, 4'h2, 4'h8, 4'hB},
        '{4'hD, 4'hB, 4'h7, 4'hE, 4'hC, 4'h1, 4'h3, 4'h9, 4'h5, 4'h0, 4'hF, 4'h4, 4'h8, 4'h6, 4'h2, 4'hA},
        '{4'h6, 4'hF, 4'hE, 4'h9, 4'hB, 4'h3, 4'h0, 4'h8, 4'hC, 4'h2, 4'hD, 4'h7, 4'h1, 4'h4, 4'hA, 4'h5},
        '{4'hA, 4'h2, 4'h8, 4'h4, 4'h7, 4'h6, 4'h1, 4'h5, 4'hF, 4'hB, 4'h9, 4'hE, 4'h3, 4'hC, 4'hD, 4'h0}
    };

    localparam logic [31:0] BLAKE256_IV [8] = '{
        32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A,
        32'h510E527F, 32'h9B05688C, 32'h1F83D9AB, 32'h5BE0CD19
    };

    localparam logic [31:0] BLAKE256_C [16] = '{
        32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344,
        32'hA4093822, 32'h299F31D0, 32'h082EFA98, 32'hEC4E6C89,
        32'h452821E6, 32'h38D01377, 32'hBE5466CF, 32'h34E90C6C,
        32'hC0AC29B7, 32'hC97C50DD, 32'h3F84D5B5, 32'hB5470917
    };

endpackage

// File: rtl/blake_sigma_rom.sv
// Combinational sigma lookup: picks the column (diag=0) or diagonal (diag=1)
// half of one sigma row and packs it as eight nibbles, nibble k = word index.
module blake_sigma_rom
    import blake_pkg::*;
(
    input  logic [3:0]  sig,
    input  logic        diag,
    output logic [31:0] msg_sel
);

    always_comb begin
        msg_sel = '0;
        // Rows 10..15 never occur; they decode to zero rather than index out of range.
        if (sig < 4'd10) begin
            for (int k = 0; k < 8; k++) begin
                msg_sel[4*k +: 4] = SIGMA[sig][diag ? k + 8 : k];
            end
        end
    end

endmodule

// File: rtl/blake_round_ctrl.sv
// Round sequencer for the BLAKE-256 core: init, ROUNDS x (column, diagonal)
// half-rounds of G_LAT cycles each, then chaining-value finalization.
module blake_round_ctrl
    import blake_pkg::*;
#(
    parameter int unsigned ROUNDS = 14,
    parameter int unsigned G_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        start,
    output logic        busy,
    output logic        iv_load,
    output logic        v_load,
    output logic        v_we,
    output logic        h_we,
    output logic        done,
    output logic [3:0]  round,
    output logic        diag,
    output logic [31:0] msg_sel
);

    localparam logic [1:0] PH_LAST  = 2'(G_LAT - 1);
    localparam logic [3:0] RND_LAST = 4'(ROUNDS - 1);

    state_t      state, state_nxt;
    logic [1:0]  ph, ph_nxt;
    logic [3:0]  round_q, round_nxt;
    logic        diag_q, diag_nxt;
    logic [3:0]  sig, sig_nxt;
    logic        iv_q, iv_nxt;
    logic [31:0] msg_sel_q, rom_sel;
    logic        accept;

    // Host protocol: start/init are single-cycle pulses, acted on only while
    // accept is high (IDLE, or DONE where the next block may already begin);
    // busy answers a taken start in the same cycle and drops in the DONE cycle.
    assign accept = (state == ST_IDLE) || (state == ST_DONE);
    assign busy   = ((state != ST_IDLE) && (state != ST_DONE)) ||
                    (start && accept && !init);

    always_comb begin
        state_nxt = state;
        ph_nxt    = ph;
        round_nxt = round_q;
        diag_nxt  = diag_q;
        sig_nxt   = sig;
        iv_nxt    = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                state_nxt = ST_IDLE;
                if (init) begin
                    iv_nxt = 1'b1;
                end else if (start) begin
                    state_nxt = ST_VINIT;
                end
            end
            ST_VINIT: begin
                state_nxt = ST_RND;
                ph_nxt    = '0;
                round_nxt = '0;
                diag_nxt  = 1'b0;
                sig_nxt   = '0;
            end
            ST_RND: begin
                if (ph == PH_LAST) begin
                    ph_nxt = '0;
                    if (!diag_q) begin
                        diag_nxt = 1'b1;
                    end else if (round_q == RND_LAST) begin
                        // Last half-round: round/diag freeze at their final values.
                        state_nxt = ST_FINAL;
                    end else begin
                        diag_nxt  = 1'b0;
                        round_nxt = round_q + 4'd1;
                        sig_nxt   = (sig == 4'd9) ? 4'd0 : sig + 4'd1;
                    end
                end else begin
                    ph_nxt = ph + 2'd1;
                end
            end
            ST_FINAL: state_nxt = ST_DONE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Looked up from the next-cycle counters so msg_sel is registered yet aligned.
    blake_sigma_rom u_sigma_rom (
        .sig     (sig_nxt),
        .diag    (diag_nxt),
        .msg_sel (rom_sel)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ph        <= '0;
            round_q   <= '0;
            diag_q    <= 1'b0;
            sig       <= '0;
            iv_q      <= 1'b0;
            msg_sel_q <= '0;
        end else begin
            state   <= state_nxt;
            ph      <= ph_nxt;
            round_q <= round_nxt;
            diag_q  <= diag_nxt;
            sig     <= sig_nxt;
            iv_q    <= iv_nxt;
            if (state_nxt == ST_RND) begin
                msg_sel_q <= rom_sel;
            end
        end
    end

    assign iv_load = iv_q;
    assign v_load  = (state == ST_VINIT);
    assign v_we    = (state == ST_RND) && (ph == PH_LAST);
    assign h_we    = (state == ST_FINAL);
    assign done    = (state == ST_DONE);
    assign round   = round_q;
    assign diag    = diag_q;
    assign msg_sel = msg_sel_q;

endmodule

// File: tb/tb_blake_round_ctrl.sv
// Directed bench for blake_round_ctrl: default instance plus a G_LAT=2, ROUNDS=10 instance.
module tb_blake_round_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, init, start, init_p, start_p;

    logic        busy, iv_load, v_load, v_we, h_we, done, diag;
    logic [3:0]  round;
    logic [31:0] msg_sel;

    logic        busy_p, iv_load_p, v_load_p, v_we_p, h_we_p, done_p, diag_p;
    logic [3:0]  round_p;
    logic [31:0] msg_sel_p;

    int total = 0;
    int bad   = 0;

    blake_round_ctrl u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .init    (init),
        .start   (start),
        .busy    (busy),
        .iv_load (iv_load),
        .v_load  (v_load),
        .v_we    (v_we),
        .h_we    (h_we),
        .done    (done),
        .round   (round),
        .diag    (diag),
        .msg_sel (msg_sel)
    );

    blake_round_ctrl #(.ROUNDS(10), .G_LAT(2)) u_dut_p (
        .clk     (clk),
        .rst_n   (rst_n),
        .init    (init_p),
        .start   (start_p),
        .busy    (busy_p),
        .iv_load (iv_load_p),
        .v_load  (v_load_p),
        .v_we    (v_we_p),
        .h_we    (h_we_p),
        .done    (done_p),
        .round   (round_p),
        .diag    (diag_p),
        .msg_sel (msg_sel_p)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {busy, iv_load, v_load, v_we, h_we, done} for a block started in cycle 0.
    function automatic logic [5:0] exp_vec(input int c, input int glat, input int rounds);
        int rnd_end;
        rnd_end = 1 + 2 * rounds * glat;
        if (c == 0)                     return 6'b100000;
        if (c == 1)                     return 6'b101000;
        if (c >= 2 && c <= rnd_end)     return ((c - 2) % glat == glat - 1) ? 6'b100100 : 6'b100000;
        if (c == rnd_end + 1)           return 6'b100010;
        if (c == rnd_end + 2)           return 6'b000001;
        return 6'b000000;
    endfunction

    function automatic logic [5:0] obs_vec(input int which);
        if (which == 0) return {busy, iv_load, v_load, v_we, h_we, done};
        return {busy_p, iv_load_p, v_load_p, v_we_p, h_we_p, done_p};
    endfunction

    task automatic drive(input int which, input logic s, input logic i);
        if (which == 0) begin
            start = s;
            init  = i;
        end else begin
            start_p = s;
            init_p  = i;
        end
    endtask

    // Entered and left 1 time unit after a rising edge; cmd_at < 0 means no stray command.
    task automatic run_seq(input int which, input int glat, input int rounds,
                           input int cmd_at, input string name);
        int last;
        last = 5 + 2 * rounds * glat;
        for (int c = 0; c < last; c++) begin
            drive(which, (c == 0) || (c == cmd_at), (c == cmd_at) && (c != 0));
            #1;
            chk($sformatf("%s strobes c%0d", name, c), {26'd0, obs_vec(which)},
                {26'd0, exp_vec(c, glat, rounds)});
            if (which == 0) begin
                case (c)
                    2:  begin chk($sformatf("%s r0 col", name), msg_sel, 32'h76543210);
                              chk($sformatf("%s r0 col rd", name), {27'd0, round, diag}, 32'h0); end
                    3:  begin chk($sformatf("%s r0 diag", name), msg_sel, 32'hFEDCBA98);
                              chk($sformatf("%s r0 diag rd", name), {27'd0, round, diag}, 32'h1); end
                    4:  begin chk($sformatf("%s r1 col", name), msg_sel, 32'h6DF984AE);
                              chk($sformatf("%s r1 col rd", name), {27'd0, round, diag}, 32'h2); end
                    5:  chk($sformatf("%s r1 diag", name), msg_sel, 32'h357B20C1);
                    22: begin chk($sformatf("%s r10 col", name), msg_sel, 32'h76543210);
                              chk($sformatf("%s r10 col rd", name), {27'd0, round, diag}, 32'h14); end
                    29: chk($sformatf("%s r13 diag", name), msg_sel, 32'h8F04A562);
                    31: begin chk($sformatf("%s hold sel", name), msg_sel, 32'h8F04A562);
                              chk($sformatf("%s hold rd", name), {27'd0, round, diag}, 32'h1B); end
                    default: ;
                endcase
            end else begin
                case (c)
                    3:  begin chk($sformatf("%s r0 col", name), msg_sel_p, 32'h76543210);
                              chk($sformatf("%s r0 col rd", name), {27'd0, round_p, diag_p}, 32'h0); end
                    41: begin chk($sformatf("%s r9 diag", name), msg_sel_p, 32'h0DC3E9BF);
                              chk($sformatf("%s r9 diag rd", name), {27'd0, round_p, diag_p}, 32'h13); end
                    default: ;
                endcase
            end
            @(posedge clk);
            #1;
        end
        drive(which, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n   = 1'b0;
        init    = 1'b0;
        start   = 1'b0;
        init_p  = 1'b0;
        start_p = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset strobes", {26'd0, obs_vec(0)}, 32'h0);
        chk("reset msg_sel", msg_sel, 32'h0);
        chk("reset round/diag", {27'd0, round, diag}, 32'h0);
        chk("reset strobes p", {26'd0, obs_vec(1)}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_seq(0, 1, 14, -1, "dflt");
        run_seq(0, 1, 14, 10, "ign");

        // init and start together in IDLE: IV load only.
        init  = 1'b1;
        start = 1'b1;
        #1;
        chk("init prio busy", {31'd0, busy}, 32'h0);
        @(posedge clk);
        #1;
        init  = 1'b0;
        start = 1'b0;
        #1;
        chk("init prio c1", {26'd0, obs_vec(0)}, 32'b010000);
        @(posedge clk);
        #2;
        chk("init prio c2", {26'd0, obs_vec(0)}, 32'h0);
        @(posedge clk);
        #1;

        // Reset asserted for one cycle at cycle 15 of a running block.
        for (int c = 0; c <= 15; c++) begin
            start = (c == 0);
            if (c == 15) rst_n = 1'b0;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("mid rst strobes", {26'd0, obs_vec(0)}, 32'h0);
        chk("mid rst msg_sel", msg_sel, 32'h0);
        chk("mid rst round/diag", {27'd0, round, diag}, 32'h0);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #2;
            chk($sformatf("post rst quiet c%0d", c), {26'd0, obs_vec(0)}, 32'h0);
        end
        @(posedge clk);
        #1;
        run_seq(0, 1, 14, -1, "after_rst");

        run_seq(1, 2, 10, -1, "p");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
